// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a main + skid buffer so in_ready
// is registered, plus flush, NOP substitution for masked lanes and a stall counter.
module ifid_skid_stage #(
  parameter int unsigned           LANES    = 2,
  parameter int unsigned           INST_W   = 32,
  parameter int unsigned           PC_W     = 32,
  parameter logic [INST_W-1:0]     NOP_INST = 32'h00000013,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [LANES*INST_W-1:0]   in_inst,
  input  logic [LANES-1:0]          in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           out_pc,
  output logic [LANES*INST_W-1:0]   out_inst,
  output logic [LANES-1:0]          out_mask,
  input  logic                      flush,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic                    main_valid;
  logic                    skid_valid;
  logic [PC_W-1:0]         skid_pc;
  logic [LANES*INST_W-1:0] skid_inst;
  logic [LANES-1:0]        skid_mask;
  logic [LANES*INST_W-1:0] cap_inst;
  logic                    accept;
  logic                    deliver;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign deliver   = main_valid && out_ready;

  always_comb begin
    cap_inst = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cap_inst[i*INST_W +: INST_W] = in_mask[i] ? in_inst[i*INST_W +: INST_W] : NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_pc     <= '0;
      out_inst   <= '0;
      out_mask   <= '0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      skid_mask  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      // Flush only clears the valid bits; data registers keep stale contents.
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (deliver) begin
          out_pc     <= skid_pc;
          out_inst   <= skid_inst;
          out_mask   <= skid_mask;
          skid_valid <= 1'b0;
        end
      end else if (!main_valid || deliver) begin
        main_valid <= accept;
        if (accept) begin
          out_pc   <= in_pc;
          out_inst <= cap_inst;
          out_mask <= in_mask;
        end
      end else if (accept) begin
        skid_pc    <= in_pc;
        skid_inst  <= cap_inst;
        skid_mask  <= in_mask;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: directed and random beats checked against a queue model
// of held beats; a second instance with a 4-bit counter covers saturation.
module tb_ifid_skid_stage;

  localparam int unsigned LANES  = 2;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  mask;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_mask;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_pc, b_out_pc;
  logic [63:0] a_out_inst, b_out_inst;
  logic [1:0]  a_out_mask, b_out_mask;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  beat_t       q[$];
  int unsigned stall;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ifid_skid_stage #(.LANES(LANES), .INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_mask(in_mask), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_inst(a_out_inst), .out_mask(a_out_mask), .flush(flush),
    .stall_cnt(a_stall)
  );

  ifid_skid_stage #(.LANES(LANES), .INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_mask(in_mask), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .out_mask(b_out_mask), .flush(flush),
    .stall_cnt(b_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] masked(input logic [63:0] inst, input logic [1:0] m);
    logic [63:0] r;
    r[31:0]  = m[0] ? inst[31:0]  : NOP;
    r[63:32] = m[1] ? inst[63:32] : NOP;
    return r;
  endfunction

  task automatic check_outputs();
    int unsigned e16, e4;
    e16 = (stall > 65535) ? 65535 : stall;
    e4  = (stall > 15) ? 15 : stall;
    chk("out_valid",   64'(a_out_valid), 64'(q.size() > 0));
    chk("in_ready",    64'(a_in_ready),  64'(q.size() < 2));
    chk("stall16",     64'(a_stall),     64'(e16));
    chk("stall4",      64'(b_stall),     64'(e4));
    chk("out_valid4",  64'(b_out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_pc",    64'(a_out_pc),    64'(q[0].pc));
      chk("out_inst",  a_out_inst,       q[0].inst);
      chk("out_mask",  64'(a_out_mask),  64'(q[0].mask));
      chk("out_inst4", b_out_inst,       q[0].inst);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                      input logic [1:0] m, input logic ordy, input logic fl);
    beat_t b;
    logic  acc, del;
    in_valid = v; in_pc = pc; in_inst = inst; in_mask = m; out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    del = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy) stall++;
    if (fl) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) begin
        b.pc = pc; b.inst = masked(inst, m); b.mask = m;
        q.push_back(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
    #1;
    q.delete();
    stall = 0;
    chk("rst_out_valid", 64'(a_out_valid), 64'(0));
    chk("rst_stall16",   64'(a_stall),     64'(0));
    chk("rst_stall4",    64'(b_stall),     64'(0));
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);
  endtask

  initial begin
    logic [63:0] w;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_inst = '0; in_mask = '0;
    stall = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(a_out_valid), 64'(0));
    chk("reset_pc",    64'(a_out_pc),    64'(0));
    chk("reset_inst",  a_out_inst,       64'(0));
    chk("reset_mask",  64'(a_out_mask),  64'(0));
    chk("reset_stall", 64'(a_stall),     64'(0));
    rst = 1'b1;
    idle(1'b1);

    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h1000 + 32'(i) * 8, {$urandom, $urandom}, 2'b11, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h2000 + 32'(i) * 8, {$urandom, $urandom}, 2'b11, (i < 2), 1'b0);
    chk("bp_stall4", 64'(a_stall), 64'(4));
    for (int i = 0; i < 4; i++) idle(1'b1);

    step(1'b1, 32'h3000, {32'hDEADBEEF, 32'h12345678}, 2'b01, 1'b1, 1'b0);
    w = a_out_inst;
    chk("mask_lane1", 64'(w[63:32]), 64'(NOP));
    chk("mask_lane0", 64'(w[31:0]),  64'(32'h12345678));
    idle(1'b1);

    step(1'b1, 32'h4000, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    step(1'b1, 32'h4008, {$urandom, $urandom}, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'h4010, {$urandom, $urandom}, 2'b11, 1'b0, 1'b1);
    chk("flush_in_ready", 64'(a_in_ready), 64'(1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    step(1'b1, 32'h5000, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    step(1'b1, 32'h5008, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    async_reset();

    step(1'b1, 32'h6000, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("sat_stall4", 64'(b_stall), 64'(15));
    for (int i = 0; i < 2; i++) idle(1'b1);

    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, $urandom, {$urandom, $urandom}, 2'($urandom),
           ($urandom % 3) != 0, ($urandom % 20) == 0);

    step(1'b1, 32'h7000, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    step(1'b1, 32'h7008, {$urandom, $urandom}, 2'b11, 1'b0, 1'b0);
    async_reset();
    chk("post_rst_in_ready", 64'(a_in_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised IF/ID pipeline stage that supersedes the plain IF/ID register.
- Carries LANES instruction slots plus PC and lane mask from fetch to decode over a valid/ready handshake.
- A two-entry (main + skid) buffer gives full throughput with a registered in_ready.
- Adds synchronous flush, NOP substitution for masked lanes, and a saturating back-pressure counter.

Parameters:
- LANES, 2, instruction slots per beat (1..4)
- INST_W, 32, width of one instruction slot
- PC_W, 32, fetch PC width
- NOP_INST, 32'h00000013, encoding written into masked-off lanes
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch beat valid
- in_ready  out  1  stage can accept a beat
- in_pc  in  PC_W  PC of lane 0
- in_inst  in  LANES*INST_W  packed instructions, lane 0 in LSBs
- in_mask  in  LANES  lane valid bits
- out_valid  out  1  decode beat valid
- out_ready  in  1  decode accepts beat
- out_pc  out  PC_W  registered PC
- out_inst  out  LANES*INST_W  registered instructions, masked lanes = NOP_INST
- out_mask  out  LANES  registered lane mask
- flush  in  1  synchronous kill of all held and incoming beats
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=0, async): main_valid=0, skid_valid=0, out_pc/out_inst/out_mask=0, stall_cnt=0, in_ready=1 once reset is released.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Accept: in_valid & in_ready & !flush. Deliver: out_valid & out_ready. out_valid = main_valid; out_* are driven from the main entry.
- Capture: for each lane i, the stored inst = in_mask[i] ? in_inst[i] : NOP_INST. PC and mask are stored unchanged.
- Latency: a beat accepted into an empty stage appears on out_* the next cycle.
- Next-state table, when not flushing:
  - main empty, accept -> main loaded.
  - main full, deliver, skid empty, accept -> main reloaded with the input; full throughput of 1 beat/cycle.
  - main full, deliver, skid empty, no accept -> main empty.
  - main full, no deliver, accept -> skid loaded; in_ready drops next cycle.
  - skid full, deliver -> skid moves to main, skid empty; in_ready=1 next cycle. No accept is possible this cycle.
  - skid full, no deliver -> hold everything.
- Ordering: beats leave in acceptance order. The stage never drops or duplicates a beat except on flush.
- Flush (highest priority):
  - The next cycle has main_valid=0 and skid_valid=0.
  - The input beat in the flush cycle is not accepted, even if in_valid & in_ready.
  - The main beat presented in the flush cycle still counts as delivered if out_ready=1. Downstream must ignore it by its own flush.
  - Data registers are not cleared by flush.
- Reset mid-operation: all held beats are discarded immediately (async). out_valid=0 while rst=0.
- stall_cnt:
  - Increments by 1 each cycle that out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; not by flush.
- Data lines with valid=0 may hold stale values. Benches check out_* only when out_valid=1.

Test Plan:
- Streaming: out_ready=1, 10 back-to-back beats with PC 0x1000, 0x1008, ... -> identical sequence on out_* with 1-cycle latency; in_ready stays 1; stall_cnt=0.
- Back-pressure: out_ready=0 from cycle 3 for 4 cycles while in_valid=1 -> skid fills, in_ready=0 from the next cycle; stall_cnt=4; after release, beats emerge in order with none lost.
- Lane mask: in_mask=2'b01, lane1 inst=0xDEADBEEF -> out_inst lane1=0x00000013, lane0 unchanged, out_mask=2'b01.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input does not appear later.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a held beat -> stall_cnt=15 and stays there.
- Async reset: assert rst=0 mid-clock while main and skid are full -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge; in_ready=1 after release.
